// File: rtl/discrete_mixer_pkg.sv
// Shared types and constants for the discrete audio mixer.
// Optional clip counter is enabled with DISCRETE_MIXER_CLIP_COUNT_EN.
package discrete_mixer_pkg;

    localparam int DEF_GAIN_FRAC_BITS = 14;

    localparam logic signed [15:0] GAIN_UNITY = 16'sh4000;

    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } mixer_state_t;

endpackage

// File: rtl/audio_round_saturate.sv
// Rounds a fixed-point accumulator (half toward +inf) and clamps
// it to a signed 16-bit sample, flagging when clamping occurred.
module audio_round_saturate
    import discrete_mixer_pkg::*;
#(
    parameter int ACC_WIDTH = 34,
    parameter int FRAC_BITS = 14
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [15:0]          sample,
    output logic                        clipped
);

    localparam int RW = ACC_WIDTH + 1;

    localparam logic signed [RW-1:0] HALF  = RW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [RW-1:0] S_MAX = RW'(SAMPLE_MAX);
    localparam logic signed [RW-1:0] S_MIN = RW'(SAMPLE_MIN);

    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] rounded;

    // One guard bit keeps the rounding bias from wrapping.
    always_comb begin
        biased  = {acc[ACC_WIDTH-1], acc} + HALF;
        rounded = biased >>> FRAC_BITS;
        clipped = 1'b1;
        if (rounded > S_MAX) begin
            sample = 16'sh7FFF;
        end else if (rounded < S_MIN) begin
            sample = 16'sh8000;
        end else begin
            sample  = rounded[15:0];
            clipped = 1'b0;
        end
    end

endmodule

// File: rtl/discrete_audio_mixer.sv
// Time-multiplexed weighted mixer for the per-voice filter outputs.
// Define DISCRETE_MIXER_CLIP_COUNT_EN to add the clip counter ports.
module discrete_audio_mixer
    import discrete_mixer_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int GAIN_FRAC_BITS = DEF_GAIN_FRAC_BITS,
    parameter int ACC_WIDTH      = 32 + $clog2(NUM_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         I_RSTn,
    input  logic                         audio_clk_en,
    input  logic [16*NUM_CHANNELS-1:0]   in_flat,
    input  logic [16*NUM_CHANNELS-1:0]   gain_flat,
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    input  logic                         clip_clear,
    output logic [15:0]                  clip_count,
`endif
    output logic signed [15:0]           out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IW = $clog2(NUM_CHANNELS + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_CHANNELS);

    mixer_state_t state;
    mixer_state_t state_nxt;

    logic signed [15:0] snap_in   [NUM_CHANNELS];
    logic signed [15:0] snap_gain [NUM_CHANNELS];

    logic [IW-1:0]              idx;
    logic signed [31:0]         prod;
    logic signed [31:0]         prod_r;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [15:0]         sat;
    logic                       clipped;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (audio_clk_en) state_nxt = ACCUM;
            ACCUM:   if (idx == LAST) state_nxt = OUTPUT;
            OUTPUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        prod = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (idx == IW'(k)) prod = snap_in[k] * snap_gain[k];
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && audio_clk_en) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                snap_in[k]   <= in_flat[16*k +: 16];
                snap_gain[k] <= gain_flat[16*k +: 16];
            end
        end
    end

    // Products are registered one clk ahead of the add; the extra
    // ACCUM cycle at idx == LAST drains the last product.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            prod_r    <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (audio_clk_en && state != IDLE) overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (audio_clk_en) begin
                        acc    <= '0;
                        idx    <= '0;
                        prod_r <= '0;
                        busy   <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc    <= acc + ACC_WIDTH'(prod_r);
                    prod_r <= prod;
                    idx    <= idx + 1'b1;
                end
                OUTPUT: begin
                    out       <= sat;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    audio_round_saturate #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (GAIN_FRAC_BITS)
    ) u_round_sat (
        .acc     (acc),
        .sample  (sat),
        .clipped (clipped)
    );

`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            clip_count <= '0;
        end else if (clip_clear) begin
            clip_count <= '0;
        end else if (state == OUTPUT && clipped && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`else
    logic unused_clipped;
    assign unused_clipped = clipped;
`endif

endmodule

// File: tb/tb_discrete_audio_mixer.sv
// Scoreboard bench for discrete_audio_mixer (latency, rounding,
// saturation, overrun and reset behaviour).
module tb_discrete_audio_mixer;

    localparam int N = 4;

    logic                    clk = 1'b0;
    logic                    I_RSTn = 1'b0;
    logic                    audio_clk_en = 1'b0;
    logic [16*N-1:0]         in_flat = '0;
    logic [16*N-1:0]         gain_flat = '0;
    logic signed [15:0]      out;
    logic                    out_valid;
    logic                    busy;
    logic                    overrun;
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
    logic                    clip_clear = 1'b0;
    logic [15:0]             clip_count;
`endif

    int checks = 0;
    int errors = 0;
    logic signed [15:0] exp_q[$];

    always #5 clk = ~clk;

    discrete_audio_mixer #(.NUM_CHANNELS(N)) dut (
        .clk          (clk),
        .I_RSTn       (I_RSTn),
        .audio_clk_en (audio_clk_en),
        .in_flat      (in_flat),
        .gain_flat    (gain_flat),
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
        .clip_clear   (clip_clear),
        .clip_count   (clip_count),
`endif
        .out          (out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Reference: exact integer sum, floor((s + 8192) / 16384), clamp.
    function automatic logic signed [15:0] model(input logic [16*N-1:0] i,
                                                 input logic [16*N-1:0] g);
        longint s;
        longint r;
        longint q;
        logic signed [15:0] a;
        logic signed [15:0] b;
        s = 0;
        for (int k = 0; k < N; k++) begin
            a = i[16*k +: 16];
            b = g[16*k +: 16];
            s = s + longint'(a) * longint'(b);
        end
        r = s + 8192;
        if (r >= 0) q = r / 16384;
        else        q = -((-r + 16383) / 16384);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    always @(negedge clk) begin
        if (I_RSTn && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid out=%0d", out);
            end else begin
                logic signed [15:0] e;
                e = exp_q.pop_front();
                if (out !== e) begin
                    errors++;
                    $display("FAIL mix_out got=%0d want=%0d", out, e);
                end
            end
        end
    end

    task automatic set_ch(input int k, input int v, input logic [15:0] g);
        in_flat[16*k +: 16]   = 16'(v);
        gain_flat[16*k +: 16] = g;
    endtask

    task automatic clear_ch();
        in_flat   = '0;
        gain_flat = '0;
    endtask

    task automatic do_reset();
        I_RSTn = 1'b0;
        @(posedge clk);
        #1;
        I_RSTn = 1'b1;
        exp_q.delete();
    endtask

    // Called 1ns after a posedge; the strobe is sampled at the next edge T.
    task automatic start_mix();
        exp_q.push_back(model(in_flat, gain_flat));
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
    endtask

    // Expects out_valid lat edges from now; optionally checks busy.
    task automatic wait_valid(input int lat, input bit chk_busy);
        int  seen;
        bit  got;
        seen = 0;
        got  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (chk_busy && c <= lat) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during got=%b want=1 step=%0d", busy, c);
                end
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                got  = 1'b1;
                seen = c;
                break;
            end
        end
        checks++;
        if (!got || seen != lat) begin
            errors++;
            $display("FAIL latency got=%0d want=%0d", seen, lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after got=%b want=0", busy);
        end
    endtask

    task automatic test_reset();
        I_RSTn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 16'sd0) begin
            errors++;
            $display("FAIL rst_out got=%0d want=0", out);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got=%b%b want=00", out_valid, busy);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_overrun got=%b want=0", overrun);
        end
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
        checks++;
        if (clip_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_clip got=%0d want=0", clip_count);
        end
`endif
        I_RSTn = 1'b1;
    endtask

    task automatic test_basic();
        clear_ch();
        set_ch(0, 1000, 16'h4000);
        start_mix();
        wait_valid(6, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 16'sd1000) begin
            errors++;
            $display("FAIL hold got=%0d/%b want=1000/0", out, out_valid);
        end
    endtask

    task automatic test_saturate();
        clear_ch();
        for (int k = 0; k < N; k++) set_ch(k, 30000, 16'h4000);
        start_mix();
        wait_valid(6, 1'b0);
        for (int k = 0; k < N; k++) set_ch(k, -30000, 16'h4000);
        start_mix();
        wait_valid(6, 1'b0);
`ifdef DISCRETE_MIXER_CLIP_COUNT_EN
        checks++;
        if (clip_count !== 16'd2) begin
            errors++;
            $display("FAIL clip_count got=%0d want=2", clip_count);
        end
        clip_clear = 1'b1;
        @(posedge clk);
        #1;
        clip_clear = 1'b0;
        checks++;
        if (clip_count !== 16'd0) begin
            errors++;
            $display("FAIL clip_clear got=%0d want=0", clip_count);
        end
`endif
    endtask

    task automatic test_mixed();
        clear_ch();
        set_ch(0, 1234, 16'hC000);
        set_ch(1, -500, 16'h2000);
        start_mix();
        wait_valid(6, 1'b0);
        checks++;
        if (out !== -16'sd1484) begin
            errors++;
            $display("FAIL mixed got=%0d want=-1484", out);
        end
    endtask

    task automatic test_rounding();
        int vals [3] = '{1, -1, 3};
        for (int i = 0; i < 3; i++) begin
            clear_ch();
            set_ch(0, vals[i], 16'h2000);
            start_mix();
            wait_valid(6, 1'b0);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        clear_ch();
        set_ch(0, 100, 16'h4000);
        start_mix();
        @(posedge clk);
        #1;
        set_ch(0, 7777, 16'h4000);
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_mid got=%b want=1", overrun);
        end
        wait_valid(4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (overrun !== 1'b1 || out !== 16'sd100) begin
            errors++;
            $display("FAIL overrun_sticky got=%b/%0d want=1/100", overrun, out);
        end

        do_reset();
        clear_ch();
        set_ch(0, 321, 16'h4000);
        start_mix();
        repeat (5) @(posedge clk);
        #1;
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_edge got=%b/%b want=1/1", overrun, out_valid);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drop got=%0d/%b want=0/0", exp_q.size(), busy);
        end

        do_reset();
        clear_ch();
        set_ch(0, 250, 16'h4000);
        start_mix();
        wait_valid(6, 1'b0);
        set_ch(0, -2000, 16'h4000);
        set_ch(2, 800, 16'h2000);
        start_mix();
        wait_valid(6, 1'b1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_overrun got=%b want=0", overrun);
        end
    endtask

    task automatic test_reset_midmix();
        do_reset();
        clear_ch();
        set_ch(0, 500, 16'h4000);
        start_mix();
        wait_valid(6, 1'b0);
        set_ch(0, 9000, 16'h4000);
        audio_clk_en = 1'b1;
        @(posedge clk);
        #1;
        audio_clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        I_RSTn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out !== 16'sd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midmix_rst got=%0d/%b/%b want=0/0/0", out, out_valid, busy);
        end
        I_RSTn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (out !== 16'sd0) begin
            errors++;
            $display("FAIL midmix_hold got=%0d want=0", out);
        end
        set_ch(0, -4321, 16'h4000);
        start_mix();
        wait_valid(6, 1'b1);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_mixed();
        test_rounding();
        test_overrun();
        test_reset_midmix();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
